cam_capture: RTL



---
 rtl/cam_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
// Camera capture front end: synchronizes a parallel RGB565 camera bus into
// the clk domain, captures one frame per start request, and writes the
// 4-bit green component of each pixel into the frame buffer.
module cam_capture #(
  parameter int ram_addwidth = 4,
  parameter int num_pixels   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    cam_pclk,
  input  logic                    cam_vsync,
  input  logic                    cam_href,
  input  logic [7:0]              cam_data,
  output logic [ram_addwidth-1:0] wr_add,
  output logic [3:0]              wr_data,
  output logic                    wr_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [ram_addwidth:0]   frame_pixels
);

  localparam logic [2:0] st_idle = 3'd0;
  localparam logic [2:0] st_arm  = 3'd1;
  localparam logic [2:0] st_sync = 3'd2;
  localparam logic [2:0] st_capt = 3'd3;
  localparam logic [2:0] st_done = 3'd4;

  localparam logic [ram_addwidth:0] pix_max_c = (ram_addwidth+1)'(num_pixels);

  // Green G[5:2] of an RGB565 pixel: low three bits of the high byte plus
  // the top bit of the low byte.
  function automatic logic [3:0] green4(input logic [2:0] hi_bits, input logic lo_bit);
    return {hi_bits, lo_bit};
  endfunction

  logic                    pclk_m_r, pclk_s_r, pclk_d_r;
  logic                    vsync_m_r, vsync_s_r, vsync_d_r;
  logic                    href_m_r, href_s_r;
  logic [7:0]              data_m_r, data_s_r;
  logic [2:0]              state_r, state_nxt_s;
  logic                    phase_r;
  logic [2:0]              hi_r;
  logic [ram_addwidth:0]   idx_r;
  logic [ram_addwidth-1:0] wr_add_r;
  logic [3:0]              wr_data_r;
  logic                    wr_en_r, busy_r, done_r, overflow_r;
  logic [ram_addwidth:0]   frame_pixels_r;
  logic                    pclk_rise_s, vsync_rise_s, byte_ev_s;
  logic                    unused_data_bits_s;

  assign pclk_rise_s        = pclk_s_r & ~pclk_d_r;
  assign vsync_rise_s       = vsync_s_r & ~vsync_d_r;
  // A vsync rise in the same cycle as a pclk rise ends the frame; the byte is dropped.
  assign byte_ev_s          = (state_r == st_capt) && pclk_rise_s && !vsync_rise_s;
  assign unused_data_bits_s = ^data_s_r[6:3];

  // Two-flop synchronizers plus one history flop for pclk/vsync edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pclk_m_r  <= 1'b0;
      pclk_s_r  <= 1'b0;
      pclk_d_r  <= 1'b0;
      vsync_m_r <= 1'b0;
      vsync_s_r <= 1'b0;
      vsync_d_r <= 1'b0;
      href_m_r  <= 1'b0;
      href_s_r  <= 1'b0;
      data_m_r  <= 8'h00;
      data_s_r  <= 8'h00;
    end else begin
      pclk_m_r  <= cam_pclk;
      pclk_s_r  <= pclk_m_r;
      pclk_d_r  <= pclk_s_r;
      vsync_m_r <= cam_vsync;
      vsync_s_r <= vsync_m_r;
      vsync_d_r <= vsync_s_r;
      href_m_r  <= cam_href;
      href_s_r  <= href_m_r;
      data_m_r  <= cam_data;
      data_s_r  <= data_m_r;
    end
  end

  // Next-state logic for the capture sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      st_idle: if (start)         state_nxt_s = st_arm;  else state_nxt_s = st_idle;
      st_arm:  if (vsync_s_r)     state_nxt_s = st_sync; else state_nxt_s = st_arm;
      st_sync: if (!vsync_s_r)    state_nxt_s = st_capt; else state_nxt_s = st_sync;
      st_capt: if (vsync_rise_s)  state_nxt_s = st_done; else state_nxt_s = st_capt;
      st_done: state_nxt_s = st_idle;
      default: state_nxt_s = st_idle;
    endcase
  end

  // Sequencer state, byte pairing, pixel writes and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= st_idle;
      phase_r        <= 1'b0;
      hi_r           <= 3'd0;
      idx_r          <= '0;
      wr_add_r       <= '0;
      wr_data_r      <= 4'h0;
      wr_en_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      overflow_r     <= 1'b0;
      frame_pixels_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == st_arm) || (state_nxt_s == st_sync) || (state_nxt_s == st_capt);
      done_r  <= (state_nxt_s == st_done);
      wr_en_r <= 1'b0;
      if (state_r == st_idle && start) begin
        overflow_r <= 1'b0;
        idx_r      <= '0;
        phase_r    <= 1'b0;
      end else if (state_nxt_s == st_done) begin
        frame_pixels_r <= idx_r;
      end else if (byte_ev_s) begin
        if (!href_s_r) begin
          phase_r <= 1'b0;
        end else if (!phase_r) begin
          hi_r    <= data_s_r[2:0];
          phase_r <= 1'b1;
        end else begin
          phase_r <= 1'b0;
          if (idx_r < pix_max_c) begin
            wr_en_r   <= 1'b1;
            wr_add_r  <= idx_r[ram_addwidth-1:0];
            wr_data_r <= green4(hi_r, data_s_r[7]);
            idx_r     <= idx_r + 1'b1;
          end else begin
            overflow_r <= 1'b1;
          end
        end
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  assign wr_add       = wr_add_r;
  assign wr_data      = wr_data_r;
  assign wr_en        = wr_en_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overflow     = overflow_r;
  assign frame_pixels = frame_pixels_r;

endmodule
